tdl_hit_decoder: RTL and testbench

Read-side controller for the tapped-delay-line TDC front end. It gates the delay chain through its `en` input, watches the registered thermometer taps for the first hit, and converts that snapshot into a timestamp. The timestamp is a coarse clock-cycle count plus a fine tap count, delivered on a valid/ready handshake. After each hit it disables and flushes the chain before re-arming, so every delivered timestamp comes from a clean, fully zeroed line.

---
 rtl/tdl_pkg.sv | 8 +
 rtl/tdl_popcount.sv | 15 +
 rtl/tdl_hit_decoder.sv | 82 ++++++++
 tb/tb_tdl_hit_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tdl_pkg.sv
// tdl_pkg: shared state encoding and sizing helpers for the TDL hit decoder.
package tdl_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, HOLD, CLEAR} tdl_dec_state_t;
    localparam int TDL_CAPTURE_OFFSET = 2;
    function automatic int fine_w(input int taps);
        return $clog2(taps + 1);
    endfunction
endpackage

// File: rtl/tdl_popcount.sv
// tdl_popcount: combinational ones-count of a thermometer snapshot, bubble tolerant.
module tdl_popcount
    import tdl_pkg::*;
#(
    parameter int TAPS = 4,
    localparam int W = fine_w(TAPS)
) (
    input  logic [TAPS-1:0] taps,
    output logic [W-1:0]    count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < TAPS; i++) count = count + W'(taps[i]);
    end
endmodule

// File: rtl/tdl_hit_decoder.sv
// tdl_hit_decoder: gates the delay line, detects the first hit and delivers a coarse/fine timestamp.
module tdl_hit_decoder
    import tdl_pkg::*;
#(
    parameter int TAPS = 4,
    parameter int COARSE_W = 16,
    parameter int CLEAR_CYCLES = 4,
    localparam int FINE_W = fine_w(TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic [TAPS-1:0]     tap_value,
    output logic                tdl_en,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                ts_sat,
    output logic                busy
);
    localparam int CLR_W = $clog2(CLEAR_CYCLES);
    tdl_dec_state_t      state;
    logic [TAPS-1:0]     tap_q;
    logic [COARSE_W-1:0] coarse;
    logic [CLR_W-1:0]    clr;
    logic [FINE_W-1:0]   ones;
    logic                hit;
    tdl_popcount #(.TAPS(TAPS)) u_pop (.taps(tap_q), .count(ones));
    assign hit = state == ARMED && tap_q != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tap_q     <= '0;
            coarse    <= '0;
            clr       <= '0;
            tdl_en    <= 1'b0;
            ts_valid  <= 1'b0;
            ts_coarse <= '0;
            ts_fine   <= '0;
            ts_sat    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tap_q  <= tap_value;
            coarse <= coarse + COARSE_W'(1);
            case (state)
                IDLE: if (arm) begin
                    state  <= ARMED;
                    tdl_en <= 1'b1;
                    busy   <= 1'b1;
                end
                // a hit takes priority over arm being dropped in the same cycle
                ARMED: if (hit) begin
                    state     <= HOLD;
                    tdl_en    <= 1'b0;
                    ts_valid  <= 1'b1;
                    ts_coarse <= coarse;
                    ts_fine   <= ones;
                    ts_sat    <= ones == FINE_W'(TAPS);
                end else if (!arm) begin
                    state  <= IDLE;
                    tdl_en <= 1'b0;
                    busy   <= 1'b0;
                end
                HOLD: if (ts_ready) begin
                    state    <= CLEAR;
                    ts_valid <= 1'b0;
                    clr      <= CLR_W'(CLEAR_CYCLES - 1);
                end
                CLEAR: if (clr != '0) clr <= clr - CLR_W'(1);
                else if (arm) begin
                    state  <= ARMED;
                    tdl_en <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdl_hit_decoder.sv
// tb_tdl_hit_decoder: directed checks of capture, hold, clear, wrap and reset behaviour.
module tb_tdl_hit_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic [3:0]  tap_value = '0;
    logic        ts_ready = 1'b0;
    logic        tdl_en, ts_valid, ts_sat, busy;
    logic [15:0] ts_coarse;
    logic [2:0]  ts_fine;
    logic [15:0] model = '0;
    int checks = 0;
    int fails = 0;

    tdl_hit_decoder #(.TAPS(4), .COARSE_W(16), .CLEAR_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .arm(arm), .tap_value(tap_value), .tdl_en(tdl_en),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_coarse(ts_coarse),
        .ts_fine(ts_fine), .ts_sat(ts_sat), .busy(busy)
    );

    always #5 clk = ~clk;
    // reference cycle count: value the coarse counter should hold in each cycle
    always @(posedge clk) model <= rst ? 16'd0 : model + 16'd1;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_model(input logic [15:0] v);
        for (int i = 0; i < 70000 && model != v; i++) step(1);
    endtask

    // put pattern into tap_q during the cycle whose coarse value is v
    task automatic hit_at(input logic [15:0] v, input logic [3:0] pat);
        wait_model(v - 16'd1);
        tap_value = pat;
        step(1);
        tap_value = '0;
        step(1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        checks += 4;
        if (tdl_en !== 1'b0) begin fails++; $display("FAIL reset_tdl_en got %b exp 0", tdl_en); end
        if (ts_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", ts_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        if ({ts_coarse, ts_fine, ts_sat} !== 20'd0) begin fails++; $display("FAIL reset_fields got %h/%0d/%b exp 0", ts_coarse, ts_fine, ts_sat); end
        rst = 1'b0;
    endtask

    task automatic test_basic_capture;
        arm = 1'b1;
        step(1);
        checks += 2;
        if (tdl_en !== 1'b1) begin fails++; $display("FAIL arm_tdl_en got %b exp 1", tdl_en); end
        if (busy !== 1'b1) begin fails++; $display("FAIL arm_busy got %b exp 1", busy); end
        hit_at(16'd100, 4'b0011);
        checks += 4;
        if (ts_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", ts_valid); end
        if (ts_coarse !== 16'd100) begin fails++; $display("FAIL basic_coarse got %0d exp 100", ts_coarse); end
        if (ts_fine !== 3'd2 || ts_sat !== 1'b0) begin fails++; $display("FAIL basic_fine got %0d sat %b exp 2 sat 0", ts_fine, ts_sat); end
        if (tdl_en !== 1'b0) begin fails++; $display("FAIL basic_tdl_en got %b exp 0", tdl_en); end
    endtask

    task automatic test_hold_and_clear;
        for (int i = 0; i < 5; i++) begin
            tap_value = i[0] ? 4'b1111 : 4'b0101;
            step(1);
            checks++;
            if ({ts_valid, ts_coarse, ts_fine} !== {1'b1, 16'd100, 3'd2})
                begin fails++; $display("FAIL hold_frozen got v%b c%0d f%0d exp v1 c100 f2", ts_valid, ts_coarse, ts_fine); end
        end
        tap_value = '0;
        ts_ready = 1'b1;
        step(1);
        ts_ready = 1'b0;
        tap_value = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ts_valid !== 1'b0 || tdl_en !== 1'b0) begin fails++; $display("FAIL clear_cycle%0d got v%b en%b exp v0 en0", i, ts_valid, tdl_en); end
            if (i == 1) tap_value = '0;
            step(1);
        end
        checks += 2;
        if (tdl_en !== 1'b1) begin fails++; $display("FAIL rearm_tdl_en got %b exp 1", tdl_en); end
        if (ts_valid !== 1'b0) begin fails++; $display("FAIL rearm_valid got %b exp 0", ts_valid); end
        step(1);
        checks++;
        if (ts_valid !== 1'b0) begin fails++; $display("FAIL clear_residue_valid got %b exp 0", ts_valid); end
    endtask

    task automatic test_sat_and_bubble;
        logic [15:0] v;
        v = model + 16'd3;
        hit_at(v, 4'b1111);
        checks += 2;
        if (ts_fine !== 3'd4 || ts_sat !== 1'b1) begin fails++; $display("FAIL sat_fine got %0d sat %b exp 4 sat 1", ts_fine, ts_sat); end
        if (ts_coarse !== v) begin fails++; $display("FAIL sat_coarse got %0d exp %0d", ts_coarse, v); end
        ts_ready = 1'b1;
        step(1);
        checks++;
        if (ts_valid !== 1'b0) begin fails++; $display("FAIL sat_transfer got %b exp 0", ts_valid); end
        step(4);
        checks++;
        if (tdl_en !== 1'b1) begin fails++; $display("FAIL sat_rearm got %b exp 1", tdl_en); end
        hit_at(model + 16'd3, 4'b1011);
        checks += 2;
        if (ts_valid !== 1'b1) begin fails++; $display("FAIL bubble_valid got %b exp 1", ts_valid); end
        if (ts_fine !== 3'd3 || ts_sat !== 1'b0) begin fails++; $display("FAIL bubble_fine got %0d sat %b exp 3 sat 0", ts_fine, ts_sat); end
        step(1);
        checks++;
        if (ts_valid !== 1'b0) begin fails++; $display("FAIL one_cycle_hold got %b exp 0", ts_valid); end
        step(4);
    endtask

    task automatic test_wrap;
        hit_at(16'hFFFF, 4'b0001);
        checks++;
        if ({ts_valid, ts_coarse, ts_fine} !== {1'b1, 16'hFFFF, 3'd1})
            begin fails++; $display("FAIL wrap_first got v%b c%h f%0d exp v1 cffff f1", ts_valid, ts_coarse, ts_fine); end
        step(5);
        checks++;
        if (tdl_en !== 1'b1) begin fails++; $display("FAIL wrap_rearm got %b exp 1", tdl_en); end
        hit_at(16'd8, 4'b0111);
        checks++;
        if ({ts_valid, ts_coarse, ts_fine} !== {1'b1, 16'd8, 3'd3})
            begin fails++; $display("FAIL wrap_second got v%b c%h f%0d exp v1 c0008 f3", ts_valid, ts_coarse, ts_fine); end
        arm = 1'b0;
        step(5);
        checks++;
        if (busy !== 1'b0 || tdl_en !== 1'b0) begin fails++; $display("FAIL to_idle got busy%b en%b exp 0 0", busy, tdl_en); end
    endtask

    task automatic test_idle_and_arm_drop;
        ts_ready = 1'b0;
        tap_value = 4'b1111;
        step(4);
        checks++;
        if ({ts_valid, tdl_en, busy} !== 3'b000) begin fails++; $display("FAIL idle_ignore got %b exp 000", {ts_valid, tdl_en, busy}); end
        tap_value = '0;
        step(3);
        arm = 1'b1;
        step(1);
        checks++;
        if (tdl_en !== 1'b1) begin fails++; $display("FAIL drop_armed got %b exp 1", tdl_en); end
        arm = 1'b0;
        step(1);
        checks++;
        if ({tdl_en, busy, ts_valid} !== 3'b000) begin fails++; $display("FAIL drop_idle got %b exp 000", {tdl_en, busy, ts_valid}); end
        arm = 1'b1;
        step(1);
        tap_value = 4'b0011;
        step(1);
        arm = 1'b0;
        tap_value = '0;
        step(1);
        checks++;
        if (ts_valid !== 1'b1 || ts_fine !== 3'd2) begin fails++; $display("FAIL hit_beats_drop got v%b f%0d exp v1 f2", ts_valid, ts_fine); end
        step(3);
        checks++;
        if (ts_valid !== 1'b1) begin fails++; $display("FAIL hold_after_drop got %b exp 1", ts_valid); end
    endtask

    task automatic test_reset_in_hold;
        rst = 1'b1;
        ts_ready = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if ({ts_valid, busy, tdl_en, ts_coarse} !== 19'd0) begin fails++; $display("FAIL rst_hold got v%b b%b en%b c%h exp 0", ts_valid, busy, tdl_en, ts_coarse); end
        step(3);
        checks++;
        if (ts_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_no_transfer got v%b b%b exp 0 0", ts_valid, busy); end
        arm = 1'b1;
        ts_ready = 1'b0;
        hit_at(16'd7, 4'b0100);
        checks++;
        if ({ts_valid, ts_coarse, ts_fine} !== {1'b1, 16'd7, 3'd1})
            begin fails++; $display("FAIL rst_counter got v%b c%0d f%0d exp v1 c7 f1", ts_valid, ts_coarse, ts_fine); end
    endtask

    initial begin
        test_reset;
        test_basic_capture;
        test_hold_and_clear;
        test_sat_and_bubble;
        test_wrap;
        test_idle_and_arm_drop;
        test_reset_in_hold;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
